// File: rtl/seq_divider_if.sv
// Handshake and result bundle between the EX-stage control and the sequential divider.
// The master drives the request and operands; the slave returns status and results.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock, for MIPS div/divu.
// Operates on magnitudes and applies the quotient/remainder signs in a final FIX cycle.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state, next_state;
    logic   accept;

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] dividend_raw;
    logic             sign_q;
    logic             sign_r;
    logic             zero_div;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    next_state = FIX;
                end
            end
            FIX: next_state = DONE;
            DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        a_neg = bus.is_signed & bus.dividend[WIDTH-1];
        b_neg = bus.is_signed & bus.divisor[WIDTH-1];
        a_mag = a_neg ? -bus.dividend : bus.dividend;
        b_mag = b_neg ? -bus.divisor : bus.divisor;
        // The partial remainder stays below the divisor, so WIDTH bits of storage suffice;
        // only the shifted value needs the extra bit for the trial subtraction.
        rem_shift = {rem_r, quo_r[WIDTH-1]};
        trial     = rem_shift - {1'b0, div_mag};
        q_fix     = sign_q ? -quo_r : quo_r;
        r_fix     = sign_r ? -rem_r : rem_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r         <= '0;
            quo_r         <= '0;
            div_mag       <= '0;
            dividend_raw  <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            zero_div      <= 1'b0;
            cnt           <= '0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            div_by_zero_r <= 1'b0;
        end else begin
            if (accept) begin
                rem_r        <= '0;
                quo_r        <= a_mag;
                div_mag      <= b_mag;
                dividend_raw <= bus.dividend;
                sign_q       <= a_neg ^ b_neg;
                sign_r       <= a_neg;
                zero_div     <= (bus.divisor == '0);
                cnt          <= '0;
            end else if (state == RUN) begin
                if (!trial[WIDTH]) begin
                    rem_r <= trial[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                end else begin
                    rem_r <= rem_shift[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt + 1'b1;
            end

            if (state == FIX) begin
                if (zero_div) begin
                    quotient_r  <= '1;
                    remainder_r <= dividend_raw;
                end else begin
                    quotient_r  <= q_fix;
                    remainder_r <= r_fix;
                end
                div_by_zero_r <= zero_div;
            end
        end
    end

    assign bus.busy        = (state == RUN) || (state == FIX);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = div_by_zero_r;
endmodule
